// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared types and constants for the I/D memory arbiter.
// Holds FSM encoding, instruction block geometry and unified-memory region codes.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA_XFER = 2'd1,
    INST_XFER = 2'd2
  } state_t;

  localparam int INST_BEATS = 4;
  localparam int WORD_W     = 32;
  localparam int BLOCK_W    = INST_BEATS * WORD_W;
  localparam int BEAT_IDX_W = $clog2(INST_BEATS);
  localparam int BEAT_W     = BEAT_IDX_W + 1;

  localparam int   REGION_BIT  = 8;
  localparam logic REGION_INST = 1'b0;
  localparam logic REGION_DATA = 1'b1;

endpackage

// File: rtl/inst_fill_buffer.sv
// inst_fill_buffer: assembles an instruction block one 32-bit word per beat.
// Ports: CLK, RESET (sync, high), we + beat select word slot, word in, block out.
module inst_fill_buffer
  import memory_arbiter_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  we,
  input  logic [BEAT_IDX_W-1:0] beat,
  input  logic [WORD_W-1:0]     word,
  output logic [BLOCK_W-1:0]    block
);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      block <= '0;
    end else if (we) begin
      block[{beat, 5'd0} +: WORD_W] <= word;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin arbiter sharing one unified memory between I$ and D$.
// Ports: CLK/RESET; IC_* block-fill side; DC_* word side; MEM_* registered memory side.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int INST_BEATS = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         IC_READ,
  input  logic [5:0]   IC_ADDRESS,
  output logic [127:0] IC_READDATA,
  output logic         IC_BUSYWAIT,
  input  logic         DC_READ,
  input  logic         DC_WRITE,
  input  logic [5:0]   DC_ADDRESS,
  input  logic [31:0]  DC_WRITEDATA,
  output logic [31:0]  DC_READDATA,
  output logic         DC_BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [8:0]   MEM_ADDRESS,
  output logic [31:0]  MEM_WRITEDATA,
  input  logic [31:0]  MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  state_t state_q, state_d;

  logic              mem_read_d, mem_write_d;
  logic [8:0]        mem_addr_d;
  logic [31:0]       mem_wdata_d;
  logic [31:0]       dc_rdata_d;
  logic [5:0]        ic_addr_q, ic_addr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              last_q, last_d;
  logic              dc_done_q, dc_done_d;
  logic              ic_done_q, ic_done_d;
  logic              fill_we;
  logic              dreq;
  logic              strobe;

  assign dreq   = DC_READ | DC_WRITE;
  assign strobe = MEM_READ | MEM_WRITE;

  // Done flags open a one-cycle window in which the stall is lifted.
  assign DC_BUSYWAIT = dreq & ~dc_done_q;
  assign IC_BUSYWAIT = IC_READ & ~ic_done_q;

  inst_fill_buffer u_fill (
    .CLK   (CLK),
    .RESET (RESET),
    .we    (fill_we),
    .beat  (beat_q[BEAT_IDX_W-1:0]),
    .word  (MEM_READDATA),
    .block (IC_READDATA)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      DC_READDATA   <= '0;
      ic_addr_q     <= '0;
      beat_q        <= '0;
      last_q        <= REGION_INST;
      dc_done_q     <= 1'b0;
      ic_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      MEM_READ      <= mem_read_d;
      MEM_WRITE     <= mem_write_d;
      MEM_ADDRESS   <= mem_addr_d;
      MEM_WRITEDATA <= mem_wdata_d;
      DC_READDATA   <= dc_rdata_d;
      ic_addr_q     <= ic_addr_d;
      beat_q        <= beat_d;
      last_q        <= last_d;
      dc_done_q     <= dc_done_d;
      ic_done_q     <= ic_done_d;
    end
  end

  // Strobe low while in a transfer state marks the one-cycle gap after a beat.
  // last_q records the winner of the most recent contested grant.
  always_comb begin
    state_d     = state_q;
    mem_read_d  = MEM_READ;
    mem_write_d = MEM_WRITE;
    mem_addr_d  = MEM_ADDRESS;
    mem_wdata_d = MEM_WRITEDATA;
    dc_rdata_d  = DC_READDATA;
    ic_addr_d   = ic_addr_q;
    beat_d      = beat_q;
    last_d      = last_q;
    dc_done_d   = 1'b0;
    ic_done_d   = 1'b0;
    fill_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dreq && (!IC_READ || last_q == REGION_INST)) begin
          state_d     = DATA_XFER;
          mem_write_d = DC_WRITE;
          mem_read_d  = DC_READ & ~DC_WRITE;
          mem_addr_d  = {REGION_DATA, 2'b00, DC_ADDRESS};
          mem_wdata_d = DC_WRITEDATA;
          if (IC_READ) last_d = REGION_DATA;
        end else if (IC_READ) begin
          state_d     = INST_XFER;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = {REGION_INST, IC_ADDRESS, 2'b00};
          ic_addr_d   = IC_ADDRESS;
          beat_d      = '0;
          if (dreq) last_d = REGION_INST;
        end
      end
      DATA_XFER: begin
        if (strobe) begin
          if (!MEM_BUSYWAIT) begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            dc_done_d   = 1'b1;
            if (MEM_READ) dc_rdata_d = MEM_READDATA;
          end
        end else begin
          state_d = IDLE;
        end
      end
      INST_XFER: begin
        if (strobe) begin
          if (!MEM_BUSYWAIT) begin
            mem_read_d = 1'b0;
            fill_we    = 1'b1;
            beat_d     = beat_q + 1'b1;
            if (beat_q == BEAT_W'(INST_BEATS - 1)) ic_done_d = 1'b1;
          end
        end else if (beat_q == BEAT_W'(INST_BEATS)) begin
          state_d = IDLE;
          beat_d  = '0;
        end else begin
          mem_read_d = 1'b1;
          mem_addr_d = {REGION_INST, ic_addr_q, beat_q[BEAT_IDX_W-1:0]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed bench for memory_arbiter against a stalling memory.
// Memory word at address a reads {16'hC0DE, 7'h0, a} unless written.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int STALL = 5;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         IC_READ;
  logic [5:0]   IC_ADDRESS;
  logic [127:0] IC_READDATA;
  logic         IC_BUSYWAIT;
  logic         DC_READ;
  logic         DC_WRITE;
  logic [5:0]   DC_ADDRESS;
  logic [31:0]  DC_WRITEDATA;
  logic [31:0]  DC_READDATA;
  logic         DC_BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [8:0]   MEM_ADDRESS;
  logic [31:0]  MEM_WRITEDATA;
  logic [31:0]  MEM_READDATA;
  logic         MEM_BUSYWAIT;

  always #5 CLK = ~CLK;

  memory_arbiter #(.INST_BEATS(4)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .IC_READ       (IC_READ),
    .IC_ADDRESS    (IC_ADDRESS),
    .IC_READDATA   (IC_READDATA),
    .IC_BUSYWAIT   (IC_BUSYWAIT),
    .DC_READ       (DC_READ),
    .DC_WRITE      (DC_WRITE),
    .DC_ADDRESS    (DC_ADDRESS),
    .DC_WRITEDATA  (DC_WRITEDATA),
    .DC_READDATA   (DC_READDATA),
    .DC_BUSYWAIT   (DC_BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  logic [511:0] wr_valid;
  logic [31:0]  wr_data [0:511];
  int           mcnt;

  function automatic logic [31:0] pat(input logic [8:0] a);
    return {16'hC0DE, 7'h00, a};
  endfunction

  function automatic logic [31:0] mem_word(input logic [8:0] a);
    return wr_valid[a] ? wr_data[a] : pat(a);
  endfunction

  always_comb MEM_READDATA = mem_word(MEM_ADDRESS);
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mcnt < STALL);

  always @(posedge CLK) begin
    if (RESET) begin
      wr_valid <= '0;
      mcnt     <= 0;
    end else begin
      mcnt <= (MEM_READ | MEM_WRITE) ? mcnt + 1 : 0;
      if (MEM_WRITE && !MEM_BUSYWAIT) begin
        wr_valid[MEM_ADDRESS] <= 1'b1;
        wr_data[MEM_ADDRESS]  <= MEM_WRITEDATA;
      end
    end
  end

  logic [8:0] tr_addr[$];
  logic       tr_wr[$];
  int         tr_cyc[$];
  int         tr_gap[$];
  int         cyc = 0;
  int         low_run = 0;
  logic       prev_stb = 1'b0;

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (MEM_READ | MEM_WRITE) begin
      if (!prev_stb) begin
        tr_addr.push_back(MEM_ADDRESS);
        tr_wr.push_back(MEM_WRITE);
        tr_cyc.push_back(cyc);
        tr_gap.push_back(low_run);
      end
      low_run = 0;
    end else begin
      low_run = low_run + 1;
    end
    prev_stb = MEM_READ | MEM_WRITE;
  end

  function automatic logic [8:0] tr_a(input int i);
    return (i < tr_addr.size()) ? tr_addr[i] : 9'h1FF;
  endfunction

  function automatic int tr_space(input int i);
    return (i < tr_cyc.size()) ? tr_cyc[i] - tr_cyc[i-1] : -1;
  endfunction

  function automatic int tr_g(input int i);
    return (i < tr_gap.size()) ? tr_gap[i] : -1;
  endfunction

  function automatic int tr_nwr();
    int c = 0;
    foreach (tr_wr[i]) if (tr_wr[i]) c++;
    return c;
  endfunction

  task automatic tr_clear();
    tr_addr.delete();
    tr_wr.delete();
    tr_cyc.delete();
    tr_gap.delete();
  endtask

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_low(input bit inst, input int bound, output int cycles);
    cycles = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge CLK);
      if ((inst ? IC_BUSYWAIT : DC_BUSYWAIT) == 1'b0) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic wait_trace(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (tr_addr.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit ok;
    RESET = 1'b1;
    IC_READ = 1'b0;
    IC_ADDRESS = '0;
    DC_READ = 1'b0;
    DC_WRITE = 1'b0;
    DC_ADDRESS = '0;
    DC_WRITEDATA = '0;
    repeat (3) @(negedge CLK);
    chk("rst_mem_read", MEM_READ, 1'b0);
    chk("rst_mem_write", MEM_WRITE, 1'b0);
    chk("rst_mem_addr", MEM_ADDRESS, 9'h000);
    chk("rst_mem_wdata", MEM_WRITEDATA, 32'h0);
    chk("rst_ic_rdata", IC_READDATA, 128'h0);
    chk("rst_dc_rdata", DC_READDATA, 32'h0);
    chk("rst_state", dut.state_q, IDLE);
    RESET = 1'b0;
    @(negedge CLK);

    // data read, 5-cycle stall
    tr_clear();
    DC_ADDRESS = 6'h05;
    DC_READ = 1'b1;
    #1;
    chk("dc_busy_raw", DC_BUSYWAIT, 1'b1);
    wait_low(1'b0, 40, n);
    chk("dc_latency", n, 7);
    chk("dc_rdata", DC_READDATA, 32'hC0DE0105);
    chk("dc_rises", tr_addr.size(), 1);
    chk("dc_addr", tr_a(0), 9'h105);
    DC_READ = 1'b0;
    @(negedge CLK);
    chk("dc_idle_busy", DC_BUSYWAIT, 1'b0);
    chk("dc_idle_read", MEM_READ, 1'b0);
    repeat (2) @(negedge CLK);

    // instruction fill; address change mid-fill must be ignored
    tr_clear();
    IC_ADDRESS = 6'h02;
    IC_READ = 1'b1;
    repeat (3) @(negedge CLK);
    IC_ADDRESS = 6'h3F;
    wait_low(1'b1, 60, n);
    chk("ic_latency", n + 3, 28);
    chk("ic_rdata", IC_READDATA,
        {32'hC0DE000B, 32'hC0DE000A, 32'hC0DE0009, 32'hC0DE0008});
    chk("ic_rises", tr_addr.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ic_addr%0d", k), tr_a(k), 9'h008 + 9'(k));
    end
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("ic_gap%0d", k), tr_g(k), 1);
      chk($sformatf("ic_space%0d", k), tr_space(k), STALL + 2);
    end
    IC_READ = 1'b0;
    IC_ADDRESS = '0;
    @(negedge CLK);
    chk("ic_idle_busy", IC_BUSYWAIT, 1'b0);
    repeat (2) @(negedge CLK);

    // simultaneous requests after reset: data first
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    tr_clear();
    DC_ADDRESS = 6'h10;
    IC_ADDRESS = 6'h01;
    DC_READ = 1'b1;
    IC_READ = 1'b1;
    wait_low(1'b0, 40, n);
    chk("rr1_dc_latency", n, 7);
    chk("rr1_dc_rdata", DC_READDATA, 32'hC0DE0110);
    chk("rr1_ic_waiting", IC_BUSYWAIT, 1'b1);
    DC_READ = 1'b0;
    wait_low(1'b1, 60, n);
    chk("rr1_ic_done", n > 0, 1'b1);
    chk("rr1_ic_rdata", IC_READDATA,
        {32'hC0DE0007, 32'hC0DE0006, 32'hC0DE0005, 32'hC0DE0004});
    chk("rr1_first", tr_a(0), 9'h110);
    chk("rr1_second", tr_a(1), 9'h004);
    IC_READ = 1'b0;
    repeat (3) @(negedge CLK);

    // same scenario again: instruction first
    tr_clear();
    DC_ADDRESS = 6'h11;
    IC_ADDRESS = 6'h06;
    DC_READ = 1'b1;
    IC_READ = 1'b1;
    wait_low(1'b1, 60, n);
    chk("rr2_ic_latency", n, 28);
    chk("rr2_dc_waiting", DC_BUSYWAIT, 1'b1);
    chk("rr2_first", tr_a(0), 9'h018);
    IC_READ = 1'b0;
    wait_low(1'b0, 40, n);
    chk("rr2_dc_done", n > 0, 1'b1);
    chk("rr2_dc_rdata", DC_READDATA, 32'hC0DE0111);
    chk("rr2_dc_addr", tr_a(4), 9'h111);
    DC_READ = 1'b0;
    repeat (3) @(negedge CLK);

    // data write raised during instruction beat 1
    tr_clear();
    IC_ADDRESS = 6'h03;
    IC_READ = 1'b1;
    wait_trace(2, 40, ok);
    chk("wr_beat1_seen", ok, 1'b1);
    DC_ADDRESS = 6'h2A;
    DC_WRITEDATA = 32'hDEADBEEF;
    DC_WRITE = 1'b1;
    wait_low(1'b1, 60, n);
    chk("wr_ic_done", n > 0, 1'b1);
    chk("wr_held_off", tr_nwr(), 0);
    chk("wr_ic_rdata", IC_READDATA,
        {32'hC0DE000F, 32'hC0DE000E, 32'hC0DE000D, 32'hC0DE000C});
    IC_READ = 1'b0;
    wait_low(1'b0, 40, n);
    chk("wr_dc_done", n > 0, 1'b1);
    chk("wr_rises", tr_addr.size(), 5);
    chk("wr_addr", tr_a(4), 9'h12A);
    chk("wr_is_write", tr_nwr(), 1);
    chk("wr_wdata", MEM_WRITEDATA, 32'hDEADBEEF);
    chk("wr_mem", mem_word(9'h12A), 32'hDEADBEEF);
    chk("wr_rdata_kept", DC_READDATA, 32'hC0DE0111);
    DC_WRITE = 1'b0;
    repeat (3) @(negedge CLK);

    // reset during instruction beat 2
    tr_clear();
    IC_ADDRESS = 6'h04;
    IC_READ = 1'b1;
    wait_trace(3, 60, ok);
    chk("rst_beat2_seen", ok, 1'b1);
    repeat (2) @(negedge CLK);
    chk("rst_partial", IC_READDATA[63:0], {32'hC0DE0011, 32'hC0DE0010});
    RESET = 1'b1;
    @(negedge CLK);
    chk("rst_mid_read", MEM_READ, 1'b0);
    chk("rst_mid_state", dut.state_q, IDLE);
    chk("rst_mid_ic_rdata", IC_READDATA, 128'h0);
    chk("rst_mid_ic_busy", IC_BUSYWAIT, 1'b1);
    RESET = 1'b0;
    tr_clear();
    wait_low(1'b1, 60, n);
    chk("rst_re_latency", n, 28);
    chk("rst_re_addr0", tr_a(0), 9'h010);
    chk("rst_re_rdata", IC_READDATA,
        {32'hC0DE0013, 32'hC0DE0012, 32'hC0DE0011, 32'hC0DE0010});
    IC_READ = 1'b0;
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have one clock, CLK, and a synchronous, active-high reset, RESET; there are no other clocks or resets.
REQ-002 Parameter INST_BEATS, default 4, SHALL set the number of 32-bit words per instruction block; only 4 is supported.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 RESET  in  1  synchronous active-high reset.
REQ-005 IC_READ  in  1  instruction-cache block-fill request.
REQ-006 IC_ADDRESS  in  6  instruction block index (16-byte blocks).
REQ-007 IC_READDATA  out  128  assembled instruction block.
REQ-008 IC_BUSYWAIT  out  1  instruction-cache stall.
REQ-009 DC_READ  in  1  data-cache read request.
REQ-010 DC_WRITE  in  1  data-cache write request.
REQ-011 DC_ADDRESS  in  6  data block index (4-byte blocks).
REQ-012 DC_WRITEDATA  in  32  data-cache write block.
REQ-013 DC_READDATA  out  32  data-cache read block.
REQ-014 DC_BUSYWAIT  out  1  data-cache stall.
REQ-015 MEM_READ  out  1  unified-memory read strobe.
REQ-016 MEM_WRITE  out  1  unified-memory write strobe.
REQ-017 MEM_ADDRESS  out  9  unified word address; bit 8 is the region (0 = instruction, 1 = data).
REQ-018 MEM_WRITEDATA  out  32  unified-memory write word.
REQ-019 MEM_READDATA  in  32  unified-memory read word.
REQ-020 MEM_BUSYWAIT  in  1  unified-memory stall.

Function
REQ-021 The FSM SHALL have three states: IDLE, DATA_XFER and INST_XFER; all outputs to memory SHALL be registered.
REQ-022 In IDLE with only a data request pending (DC_READ or DC_WRITE), the FSM SHALL move to DATA_XFER.
- In IDLE with only IC_READ pending, it SHALL move to INST_XFER.
REQ-023 In IDLE with both requests pending, the grant SHALL go to the requester not served last (round-robin); after reset, data wins.
REQ-024 DATA_XFER SHALL drive MEM_ADDRESS = {1'b1, 2'b00, DC_ADDRESS} and MEM_WRITEDATA = DC_WRITEDATA.
- MEM_READ SHALL follow DC_READ; MEM_WRITE SHALL follow DC_WRITE.
- If DC_READ and DC_WRITE are both high, the write SHALL take precedence.
REQ-025 A beat SHALL complete at the first posedge where MEM_BUSYWAIT = 0 after the strobe has been held for at least one full cycle.
REQ-026 After each beat, strobes SHALL drop for exactly one cycle before the next beat or the return to IDLE.
REQ-027 INST_XFER SHALL issue 4 read beats with MEM_ADDRESS = {1'b0, IC_ADDRESS, beat[1:0]}, beat counting 0 to 3.
- Word k SHALL be captured into IC_READDATA[32k+31:32k].
REQ-028 An instruction fill SHALL NOT be preempted; a data request arriving mid-fill SHALL wait until the FSM returns to IDLE.
REQ-029 IC_ADDRESS and DC_ADDRESS SHALL be latched at grant; changes during a transfer SHALL be ignored.
REQ-030 DC_BUSYWAIT SHALL equal (DC_READ | DC_WRITE) except in the single cycle after data-transfer completion.
- In that cycle DC_BUSYWAIT SHALL be 0 and DC_READDATA SHALL hold the captured word.
REQ-031 IC_BUSYWAIT SHALL equal IC_READ except in the single cycle after the 4th beat completes.
- In that cycle IC_BUSYWAIT SHALL be 0 and IC_READDATA SHALL be valid.
REQ-032 A requester deasserting before completion SHALL NOT abort a started transfer; the result SHALL be discarded.
REQ-033 Minimum latency SHALL be as follows, for a memory that stalls N cycles:
- data access: grant plus N+1 cycles;
- instruction fill: 4(N+2) cycles.

Reset
REQ-034 When RESET is sampled high, the FSM SHALL go to IDLE, and the following SHALL be 0 on the next edge: MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, DC_READDATA, IC_READDATA, the beat counter and the last-served flag (last served = instruction).
REQ-035 Reset mid-transfer SHALL abandon the transfer without completing any beat; busywaits SHALL then track the raw requests.

Structure
REQ-036 Shared package memory_arbiter_pkg SHALL hold the state encoding, INST_BEATS, the region-bit position and the region codes.
REQ-037 One sub-module, inst_fill_buffer, SHALL hold the 128-bit assembly register plus its beat-indexed write enable.

Verification
REQ-038 Memory with 5-cycle stall; DC_READ at DC_ADDRESS 6'h05 -> MEM_ADDRESS 9'h105; DC_READDATA equals the memory word; DC_BUSYWAIT falls for one cycle after 7 cycles.
REQ-039 IC_READ at IC_ADDRESS 6'h02 -> MEM_ADDRESS sequence 9'h008, 9'h009, 9'h00A, 9'h00B, each separated by a one-cycle gap; IC_READDATA = {w3, w2, w1, w0}.
REQ-040 DC_READ and IC_READ rise together after reset -> data served first, then the instruction fill.
- Repeating the scenario -> the instruction fill is served first.
REQ-041 DC_WRITE of 32'hDEADBEEF raised during instruction beat 1 -> MEM_WRITE does not rise before the 4th beat completes; the write then goes to 9'h1xx.
REQ-042 RESET asserted during instruction beat 2 -> next edge: MEM_READ = 0, state IDLE, IC_READDATA = 0.
- The next IC_READ restarts at beat 0.
